// File: rtl/soi_event_capture.sv
// soi_event_capture: timestamps every level change of a 1-bit signal of interest
// and queues {level, timestamp} records in a first-word fall-through FIFO that the
// host drains with a valid/ready pop. Also keeps a saturating toggle count and a
// sticky overflow flag for events lost to a full FIFO.
//
// Optional feature: define SOI_FORCE_EN to add the host override path
// (force_en_i, force_val_i, soi_o). Without it the observed level is soi_i.
module soi_event_capture #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     soi_i,
  input  logic                     cap_en_i,
  input  logic                     clear_i,
  output logic                     ev_valid_o,
  input  logic                     ev_ready_i,
  output logic                     ev_level_o,
  output logic [TS_W-1:0]          ev_ts_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic [CNT_W-1:0]         toggle_cnt_o,
  output logic                     overflow_o
`ifdef SOI_FORCE_EN
  ,
  input  logic                     force_en_i,
  input  logic                     force_val_i,
  output logic                     soi_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0]  ts;
  logic             soi_eff;
  logic             soi_q;
  logic             primed;
  logic             event_det;

  // Pointers carry one extra MSB so full and empty are distinguishable
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [TS_W:0]    mem [DEPTH];
  logic [TS_W:0]    head;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // Last presented head, shown while the FIFO is empty
  logic             hold_level;
  logic [TS_W-1:0]  hold_ts;

`ifdef SOI_FORCE_EN
  assign soi_eff = force_en_i ? force_val_i : soi_i;
  assign soi_o   = soi_eff;
`else
  assign soi_eff = soi_i;
`endif

  assign event_det = cap_en_i && primed && (soi_eff != soi_q);

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  // clear_i overrides every push and pop in its cycle
  assign pop  = !clear_i && !empty && ev_ready_i;
  assign push = !clear_i && event_det && (!full || pop);
  assign drop = !clear_i && event_det && full && !pop;

  assign ev_valid_o = !empty;
  assign ev_level_o = empty ? hold_level : head[TS_W];
  assign ev_ts_o    = empty ? hold_ts    : head[TS_W-1:0];
  assign fill_o     = wptr - rptr;

  // Free-running timestamp, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_ONE;
    end
  end

  // Previous sample tracks even while capture is disabled; primed masks the first sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      soi_q  <= 1'b0;
      primed <= 1'b0;
    end else begin
      soi_q  <= soi_eff;
      primed <= 1'b1;
    end
  end

  // Record storage; contents are only read while the matching slot is occupied
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= {soi_eff, ts};
    end
  end

  // FIFO pointers; a push into a full FIFO with a pop reuses the slot being freed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Capture the head each cycle it is presented so outputs hold once the FIFO drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_level <= 1'b0;
      hold_ts    <= '0;
    end else if (!empty) begin
      hold_level <= head[TS_W];
      hold_ts    <= head[TS_W-1:0];
    end
  end

  // Saturating event count; dropped events still count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_cnt_o <= '0;
    end else if (clear_i) begin
      toggle_cnt_o <= '0;
    end else if (event_det && (toggle_cnt_o != CNT_MAX)) begin
      toggle_cnt_o <= toggle_cnt_o + CNT_ONE;
    end
  end

  // Sticky flag for records lost to a full FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_soi_event_capture.sv
// Bench for soi_event_capture: a queue-based reference model checked against the
// DUT on every negedge, plus hand-computed literal expectations per scenario.
module tb_soi_event_capture;

  localparam int TS_W  = 16;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int TS_MOD  = 1 << TS_W;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             soi = 1'b0;
  logic             cap_en = 1'b0;
  logic             clear = 1'b0;
  logic             ev_ready = 1'b0;
  logic             ev_valid;
  logic             ev_level;
  logic [TS_W-1:0]  ev_ts;
  logic [$clog2(DEPTH):0] fill;
  logic [CNT_W-1:0] toggle_cnt;
  logic             overflow;
`ifdef SOI_FORCE_EN
  logic             force_en = 1'b0;
  logic             force_val = 1'b0;
  logic             soi_out;
`endif

  soi_event_capture #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .soi_i        (soi),
    .cap_en_i     (cap_en),
    .clear_i      (clear),
    .ev_valid_o   (ev_valid),
    .ev_ready_i   (ev_ready),
    .ev_level_o   (ev_level),
    .ev_ts_o      (ev_ts),
    .fill_o       (fill),
    .toggle_cnt_o (toggle_cnt),
    .overflow_o   (overflow)
`ifdef SOI_FORCE_EN
    ,
    .force_en_i   (force_en),
    .force_val_i  (force_val),
    .soi_o        (soi_out)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit lvl;
    int ts;
  } rec_t;

  rec_t m_q[$];
  rec_t m_last;
  rec_t m_new;
  int   m_ts;
  bit   m_prev;
  bit   m_primed;
  int   m_cnt;
  bit   m_ovf;
  bit   m_eff;
  bit   m_ev;
  bit   m_pop;

  function automatic bit eff_level();
`ifdef SOI_FORCE_EN
    return force_en ? force_val : soi;
`else
    return soi;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_last   = '{lvl: 1'b0, ts: 0};
      m_ts     = 0;
      m_prev   = 1'b0;
      m_primed = 1'b0;
      m_cnt    = 0;
      m_ovf    = 1'b0;
    end else begin
      m_eff = eff_level();
      if (m_q.size() > 0) m_last = m_q[0];
      m_ev = cap_en && m_primed && (m_eff != m_prev);
      if (clear) begin
        m_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
      end else begin
        m_pop = (m_q.size() > 0) && ev_ready;
        if (m_pop) void'(m_q.pop_front());
        if (m_ev) begin
          if (m_cnt < CNT_TOP) m_cnt++;
          // a pop this cycle frees a slot for the push
          if (m_q.size() >= DEPTH) begin
            m_ovf = 1'b1;
          end else begin
            m_new = '{lvl: m_eff, ts: m_ts};
            m_q.push_back(m_new);
          end
        end
      end
      m_prev   = m_eff;
      m_primed = 1'b1;
      m_ts     = (m_ts + 1) % TS_MOD;
    end
  end

  // Continuous comparison against the model
  always @(negedge clk) begin
    chk("valid",    int'(ev_valid),   int'(m_q.size() > 0));
    chk("level",    int'(ev_level),   int'((m_q.size() > 0) ? m_q[0].lvl : m_last.lvl));
    chk("ts",       int'(ev_ts),      (m_q.size() > 0) ? m_q[0].ts : m_last.ts);
    chk("fill",     int'(fill),       m_q.size());
    chk("cnt",      int'(toggle_cnt), m_cnt);
    chk("overflow", int'(overflow),   int'(m_ovf));
`ifdef SOI_FORCE_EN
    chk("soi_o",    int'(soi_out),    int'(eff_level()));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Afterwards inputs set now are sampled in the cycle whose timestamp is t
  task automatic goto_ts(input int t);
    int guard = 0;
    while (m_ts != t && guard < 70000) begin
      tick();
      guard++;
    end
    chk("goto_ts_reached", m_ts, t);
  endtask

  task automatic do_reset(input logic soi_level);
    soi = soi_level;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  int  t4;
  bit  l4;

  initial begin
    cap_en = 1'b1;

    // 1: release with soi held high -> priming only, no events
    do_reset(1'b1);
    repeat (20) tick();
    chk("t1_valid", int'(ev_valid), 0);
    chk("t1_fill", int'(fill), 0);
    chk("t1_cnt", int'(toggle_cnt), 0);

    // 2: four changes at ts 10..13, no pops
    do_reset(1'b0);
    goto_ts(10);
    chk("t2_valid_before", int'(ev_valid), 0);
    soi = 1'b1; tick();
    chk("t2_valid_at_ts11", int'(ev_valid), 1);
    soi = 1'b0; tick();
    soi = 1'b1; tick();
    soi = 1'b0; tick();
    chk("t2_fill", int'(fill), 4);
    ev_ready = 1'b1;
    chk("t2_pop0_lvl", int'(ev_level), 1); chk("t2_pop0_ts", int'(ev_ts), 10); tick();
    chk("t2_pop1_lvl", int'(ev_level), 0); chk("t2_pop1_ts", int'(ev_ts), 11); tick();
    chk("t2_pop2_lvl", int'(ev_level), 1); chk("t2_pop2_ts", int'(ev_ts), 12); tick();
    chk("t2_pop3_lvl", int'(ev_level), 0); chk("t2_pop3_ts", int'(ev_ts), 13); tick();
    chk("t2_empty", int'(ev_valid), 0);
    chk("t2_hold_ts", int'(ev_ts), 13);
    ev_ready = 1'b0;

    // 3: ten toggles into an 8-deep FIFO, then clear
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      soi = ~soi; tick();
    end
    chk("t3_fill", int'(fill), 8);
    chk("t3_cnt", int'(toggle_cnt), 10);
    chk("t3_ovf", int'(overflow), 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t3_clr_fill", int'(fill), 0);
    chk("t3_clr_cnt", int'(toggle_cnt), 0);
    chk("t3_clr_ovf", int'(overflow), 0);

    // 4: full FIFO plus simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      soi = ~soi; tick();
    end
    chk("t4_full", int'(fill), 8);
    chk("t4_ovf0", int'(overflow), 0);
    soi = ~soi; ev_ready = 1'b1; t4 = m_ts; l4 = soi;
    tick();
    ev_ready = 1'b0;
    chk("t4_fill_kept", int'(fill), 8);
    chk("t4_ovf_kept", int'(overflow), 0);
    chk("t4_cnt", int'(toggle_cnt), 9);
    ev_ready = 1'b1;
    repeat (7) tick();
    chk("t4_tail_ts", int'(ev_ts), t4);
    chk("t4_tail_lvl", int'(ev_level), int'(l4));
    tick();
    ev_ready = 1'b0;
    chk("t4_drained", int'(ev_valid), 0);

    // capture disabled: changes tracked but never reported, re-enable is clean
    cap_en = 1'b0;
    soi = ~soi; tick();
    soi = ~soi; tick();
    soi = ~soi; tick();
    cap_en = 1'b1; tick(); tick();
    chk("dis_fill", int'(fill), 0);
    chk("dis_cnt", int'(toggle_cnt), 9);

    // 5: timestamp wrap, then asynchronous reset with records queued
    goto_ts(16'hFFFF);
    soi = ~soi; tick();
    tick();
    soi = ~soi; tick();
    chk("t5_fill", int'(fill), 2);
    chk("t5_head_ffff", int'(ev_ts), 16'hFFFF);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    chk("t5_head_0001", int'(ev_ts), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", int'(ev_valid), 0);
    chk("t5_rst_fill", int'(fill), 0);
    chk("t5_rst_ts", int'(ev_ts), 0);
    repeat (2) tick();
    soi = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();

`ifdef SOI_FORCE_EN
    // 6: host override drives transitions with soi_i steady low
    goto_ts(50);
    force_en = 1'b1; force_val = 1'b1;
    #1 chk("t6_soi_o_hi", int'(soi_out), 1);
    goto_ts(60);
    chk("t6_soi_o_ts59", int'(soi_out), 1);
    force_en = 1'b0; force_val = 1'b0;
    #1 chk("t6_soi_o_lo", int'(soi_out), 0);
    tick();
    chk("t6_fill", int'(fill), 2);
    ev_ready = 1'b1;
    chk("t6_r0_lvl", int'(ev_level), 1); chk("t6_r0_ts", int'(ev_ts), 50); tick();
    chk("t6_r1_lvl", int'(ev_level), 0); chk("t6_r1_ts", int'(ev_ts), 60); tick();
    ev_ready = 1'b0;
    chk("t6_empty", int'(ev_valid), 0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
